// File: rtl/fios_pkg.sv
// Shared types for the FIOS result collector: limb/P-word widths, carry width and FSM states.
package fios_pkg;

  localparam int WORD_W  = 17;
  localparam int P_W     = 2 * WORD_W;
  localparam int CARRY_W = P_W - WORD_W + 1;

  typedef logic [WORD_W-1:0] limb_t;
  typedef logic [P_W-1:0]    pword_t;

  typedef enum logic [1:0] {IDLE, COLLECT, FLUSH, DONE} coll_state_t;

endpackage

// File: rtl/fios_limb_norm.sv
// One-limb normalisation stage: adds the running carry to a redundant P word and, beside it,
// subtracts a modulus limb with borrow. Purely combinational; the parent registers the results.
module fios_limb_norm
  import fios_pkg::*;
(
  input  pword_t             p,
  input  logic [CARRY_W-1:0] carry_in,
  input  logic               borrow_in,
  input  limb_t              m,
  output limb_t              limb,
  output logic [CARRY_W-1:0] carry_out,
  output limb_t              diff,
  output logic               borrow_out
);

  logic [P_W:0]    sum;
  logic [WORD_W:0] dsub;

  assign sum        = {1'b0, p} + {{(P_W + 1 - CARRY_W){1'b0}}, carry_in};
  assign limb       = sum[WORD_W-1:0];
  assign carry_out  = sum[P_W:WORD_W];

  // The top bit of the widened difference is the borrow out of this limb.
  assign dsub       = {1'b0, limb} - {1'b0, m} - {{WORD_W{1'b0}}, borrow_in};
  assign diff       = dsub[WORD_W-1:0];
  assign borrow_out = dsub[WORD_W];

endmodule

// File: rtl/fios_result_collector.sv
// Collects S redundant P words into a normalised (S+1)-limb result with valid/ready output.
// Optional macro FIOS_FINAL_SUB_EN adds the m_i port and a single conditional final subtraction.
module fios_result_collector
  import fios_pkg::*;
#(
  parameter int S = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    start_i,
  input  logic                    p_valid_i,
  input  pword_t                  p_i,
`ifdef FIOS_FINAL_SUB_EN
  input  logic [S*WORD_W-1:0]     m_i,
`endif
  output logic                    ready_o,
  output logic                    res_valid_o,
  input  logic                    res_ready_i,
  output logic [(S+1)*WORD_W-1:0] res_o,
  output logic                    err_o
);

  localparam int CNT_W = $clog2(S + 1);

  coll_state_t        state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CARRY_W-1:0] carry_q, carry_d;
  logic               err_q, err_d;
  limb_t              raw_q [S+1];
  limb_t              raw_d [S+1];
`ifdef FIOS_FINAL_SUB_EN
  limb_t              diff_q [S+1];
  limb_t              diff_d [S+1];
  logic               borrow_q, borrow_d;
`endif

  pword_t             norm_p;
  logic [CARRY_W-1:0] norm_cin, norm_cout;
  logic               norm_bin, norm_bout;
  limb_t              norm_m, norm_limb, norm_diff;
  logic               first_word, flush, take;
  logic [CNT_W-1:0]   idx;

  // Word 0 always starts from a clean chain; FLUSH feeds a zero word so limb S = carry.
  always_comb begin
    first_word = (state_q == IDLE) || (state_q == DONE);
    flush      = (state_q == FLUSH);
    norm_p     = flush ? '0 : p_i;
    norm_cin   = first_word ? '0 : carry_q;
`ifdef FIOS_FINAL_SUB_EN
    norm_bin   = first_word ? 1'b0 : borrow_q;
    norm_m     = flush ? '0 : m_i[(first_word ? 0 : int'(count_q)) * WORD_W +: WORD_W];
`else
    norm_bin   = 1'b0;
    norm_m     = '0;
`endif
  end

  fios_limb_norm u_norm (
    .p          (norm_p),
    .carry_in   (norm_cin),
    .borrow_in  (norm_bin),
    .m          (norm_m),
    .limb       (norm_limb),
    .carry_out  (norm_cout),
    .diff       (norm_diff),
    .borrow_out (norm_bout)
  );

`ifndef FIOS_FINAL_SUB_EN
  logic unused_sub;
  assign unused_sub = ^{norm_diff, norm_bout};
`endif

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    err_d   = err_q;
    raw_d   = raw_q;
`ifdef FIOS_FINAL_SUB_EN
    diff_d   = diff_q;
    borrow_d = borrow_q;
`endif
    take = 1'b0;
    idx  = count_q;

    case (state_q)
      IDLE: begin
        if (p_valid_i) begin
          if (start_i) begin
            take    = 1'b1;
            idx     = '0;
            state_d = (S == 1) ? FLUSH : COLLECT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (p_valid_i) begin
          take = 1'b1;
          if (start_i) err_d = 1'b1;
          if (count_q == CNT_W'(S - 1)) state_d = FLUSH;
        end
      end
      FLUSH: begin
        raw_d[S] = norm_limb;
`ifdef FIOS_FINAL_SUB_EN
        diff_d[S] = norm_diff;
        borrow_d  = norm_bout;
`endif
        if (carry_q[CARRY_W-1] || p_valid_i) err_d = 1'b1;
        state_d = DONE;
      end
      default: begin
        if (res_ready_i && p_valid_i && start_i) begin
          take    = 1'b1;
          idx     = '0;
          state_d = (S == 1) ? FLUSH : COLLECT;
        end else begin
          if (res_ready_i) state_d = IDLE;
          if (p_valid_i) err_d = 1'b1;
        end
      end
    endcase

    if (take) begin
      raw_d[idx] = norm_limb;
      carry_d    = norm_cout;
      count_d    = idx + CNT_W'(1);
`ifdef FIOS_FINAL_SUB_EN
      diff_d[idx] = norm_diff;
      borrow_d    = norm_bout;
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      count_q <= '0;
      carry_q <= '0;
      err_q   <= 1'b0;
      raw_q   <= '{default: '0};
`ifdef FIOS_FINAL_SUB_EN
      diff_q   <= '{default: '0};
      borrow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      err_q   <= err_d;
      raw_q   <= raw_d;
`ifdef FIOS_FINAL_SUB_EN
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
`endif
    end
  end

  assign ready_o     = (state_q == IDLE) || ((state_q == DONE) && res_ready_i);
  assign res_valid_o = (state_q == DONE);
  assign err_o       = err_q;

  // A final borrow means R < M, so the unreduced limbs are the answer.
  always_comb begin
    res_o = '0;
    for (int k = 0; k <= S; k++) begin
`ifdef FIOS_FINAL_SUB_EN
      res_o[k*WORD_W +: WORD_W] = borrow_q ? raw_q[k] : diff_q[k];
`else
      res_o[k*WORD_W +: WORD_W] = raw_q[k];
`endif
    end
  end

endmodule

// File: tb/tb_fios_result_collector.sv
// Directed self-checking bench for fios_result_collector with S=4 and a result scoreboard.
module tb_fios_result_collector;
  import fios_pkg::*;

  localparam int S  = 4;
  localparam int RW = (S + 1) * WORD_W;

  logic          clk = 1'b0;
  logic          rst, start, pv, rdy;
  pword_t        p;
  logic          ready, res_valid, err;
  logic [RW-1:0] res;
`ifdef FIOS_FINAL_SUB_EN
  logic [S*WORD_W-1:0] m = '0;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [RW-1:0] sb [$];
  logic [RW-1:0] exp_r;

  always #5 clk = ~clk;

  fios_result_collector #(.S(S)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .start_i     (start),
    .p_valid_i   (pv),
    .p_i         (p),
`ifdef FIOS_FINAL_SUB_EN
    .m_i         (m),
`endif
    .ready_o     (ready),
    .res_valid_o (res_valid),
    .res_ready_i (rdy),
    .res_o       (res),
    .err_o       (err)
  );

  function automatic logic [RW-1:0] model(input pword_t w0, w1, w2, w3);
    pword_t         w [4];
    logic [RW-1:0]  r;
    logic [P_W+1:0] s, c;
    w = '{w0, w1, w2, w3};
    r = '0;
    c = '0;
    for (int k = 0; k < 4; k++) begin
      s = {2'b00, w[k]} + c;
      r[k*WORD_W +: WORD_W] = s[WORD_W-1:0];
      c = s >> WORD_W;
    end
    r[S*WORD_W +: WORD_W] = c[WORD_W-1:0];
`ifdef FIOS_FINAL_SUB_EN
    if (r >= RW'(m)) r = r - RW'(m);
`endif
    return r;
  endfunction

  task automatic chk_res(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic word(input pword_t w, input logic st);
    p = w; start = st; pv = 1'b1;
    tick();
    p = '0; start = 1'b0; pv = 1'b0;
  endtask

  task automatic send4(input pword_t w0, w1, w2, w3, input int gap);
    sb.push_back(model(w0, w1, w2, w3));
    word(w0, 1'b1);
    repeat (gap) tick();
    word(w1, 1'b0);
    repeat (gap) tick();
    word(w2, 1'b0);
    repeat (gap) tick();
    word(w3, 1'b0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    chk_bit(tag, res_valid, 1'b1);
  endtask

  task automatic take_result(input string tag);
    wait_valid({tag, "_valid"});
    if (sb.size() != 0) exp_r = sb.pop_front();
    else exp_r = {RW{1'bx}};
    chk_res(tag, res, exp_r);
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk_bit({tag, "_ready"}, ready, 1'b1);
    chk_bit({tag, "_valid"}, res_valid, 1'b0);
    chk_res({tag, "_res"}, res, '0);
    chk_bit({tag, "_err"}, err, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; pv = 1'b0; rdy = 1'b0; p = '0;
    repeat (3) tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    // Test 1: contiguous words with latency checks
    send4(34'd1, 34'd2, 34'd3, 34'd4, 0);
    chk_bit("t1_lat_early", res_valid, 1'b0);
    tick();
    chk_bit("t1_lat_t2", res_valid, 1'b1);
    chk_bit("t1_ready_done", ready, 1'b0);
    chk_res("t1_const", res, {17'd0, 17'd4, 17'd3, 17'd2, 17'd1});
    chk_bit("t1_err", err, 1'b0);
    take_result("t1_sb");
    chk_bit("t1_idle_ready", ready, 1'b1);

    // Test 2: maximal overflow in word 0 ripples into limb 1
    send4(34'h3_FFFF_FFFF, 34'd0, 34'd0, 34'd0, 0);
    wait_valid("t2_valid");
    chk_res("t2_const", res, {17'd0, 17'd0, 17'd0, 17'h1FFFF, 17'h1FFFF});
    chk_bit("t2_err", err, 1'b0);
    take_result("t2_sb");

    // Test 3: gapped words, then host stall with a stray word
    send4(34'h3_0000_1234, 34'h1_5555_AAAA, 34'h2_FFFF_0001, 34'h0_0001_2345, 3);
    wait_valid("t3_valid");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) pv = 1'b1;
      tick();
      pv = 1'b0;
      chk_res("t3_stable", res, sb[0]);
      chk_bit("t3_ready_low", ready, 1'b0);
      chk_bit("t3_valid_held", res_valid, 1'b1);
    end
    chk_bit("t3_err", err, 1'b1);
    take_result("t3_sb");

    // Test 4: reset in the middle of a result
    word(34'h1_2345_6789, 1'b1);
    word(34'h0_0000_0777, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("t4_reset");
    send4(34'h0_00AB_CDEF, 34'h3_1111_2222, 34'h0_0000_0005, 34'h2_0000_0000, 1);
    take_result("t4_sb");
    chk_bit("t4_err", err, 1'b0);

    // Test 6: handshake and next word 0 in the same cycle
    send4(34'h0_0001_0001, 34'h1_0000_0000, 34'd7, 34'd9, 0);
    wait_valid("t6_valid");
    exp_r = sb.pop_front();
    chk_res("t6_first", res, exp_r);
    sb.push_back(model(34'h2_2222_2222, 34'h0_0000_0011, 34'h3_0000_0000, 34'd1));
    rdy = 1'b1; start = 1'b1; pv = 1'b1; p = 34'h2_2222_2222;
    #1;
    chk_bit("t6_ready_hs", ready, 1'b1);
    tick();
    rdy = 1'b0; start = 1'b0; pv = 1'b0; p = '0;
    chk_bit("t6_left_done", res_valid, 1'b0);
    word(34'h0_0000_0011, 1'b0);
    word(34'h3_0000_0000, 1'b0);
    word(34'd1, 1'b0);
    take_result("t6_second");
    chk_bit("t6_err", err, 1'b0);

`ifdef FIOS_FINAL_SUB_EN
    // Test 5: final subtraction against M = 1
    m = 68'd1;
    send4(34'd5, 34'd0, 34'd0, 34'd0, 0);
    wait_valid("t5a_valid");
    chk_res("t5a_const", res, 85'd4);
    take_result("t5a_sb");
    send4(34'd0, 34'd0, 34'd0, 34'd0, 0);
    wait_valid("t5b_valid");
    chk_res("t5b_const", res, 85'd0);
    take_result("t5b_sb");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
